input_debounce: RTL and testbench

//  Conditions a raw, asynchronous, bouncy input (switch/button) into a clean level

---
 rtl/input_debounce_pkg.sv | 9 +
 rtl/input_debounce_sync2.sv | 26 ++
 rtl/input_debounce.sv | 110 +++++++++++
 tb/tb_input_debounce.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/input_debounce_pkg.sv
// Shared definitions for debounced inputs: the debounce FSM state encoding.
package input_debounce_pkg;

   typedef enum logic {
      StStable = 1'b0,
      StCheck  = 1'b1
   } debounce_state_e;

endpackage

// File: rtl/input_debounce_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset loads RESET_LEVEL.
module input_debounce_sync2 #(
   parameter logic RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= RESET_LEVEL;
         s2_q <= RESET_LEVEL;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/input_debounce.sv
// Debounces a raw asynchronous input into a clean level plus optional one-cycle edge
// pulses. Define INPUT_DEBOUNCE_EDGE_EN to generate rise/fall; otherwise they are 0.
module input_debounce
   import input_debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4,
   parameter int unsigned CNT_W         = 8,
   parameter logic        RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

   logic            s2;
   debounce_state_e state_q;
   logic [CNT_W-1:0] cnt_q;
   logic            dout_q;

   input_debounce_sync2 #(
      .RESET_LEVEL(RESET_LEVEL)
   ) u_sync2 (
      .clk(clk),
      .rst(rst),
      .d  (din),
      .q  (s2)
   );

`ifdef INPUT_DEBOUNCE_EDGE_EN
   logic rise_q;
   logic fall_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StStable;
         cnt_q   <= '0;
         dout_q  <= RESET_LEVEL;
`ifdef INPUT_DEBOUNCE_EDGE_EN
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
`endif
      end else begin
`ifdef INPUT_DEBOUNCE_EDGE_EN
         // Pulses default low so they last exactly one clock, including when en==0.
         rise_q <= 1'b0;
         fall_q <= 1'b0;
`endif
         if (en) begin
            case (state_q)
               StStable: begin
                  if (s2 != dout_q) begin
                     if (STABLE_CYCLES == 1) begin
                        dout_q <= s2;
                        cnt_q  <= '0;
`ifdef INPUT_DEBOUNCE_EDGE_EN
                        rise_q <= s2;
                        fall_q <= ~s2;
`endif
                     end else begin
                        state_q <= StCheck;
                        cnt_q   <= CntOne;
                     end
                  end else begin
                     cnt_q <= '0;
                  end
               end
               StCheck: begin
                  if (s2 == dout_q) begin
                     state_q <= StStable;
                     cnt_q   <= '0;
                  end else if (cnt_q == CntLast) begin
                     state_q <= StStable;
                     cnt_q   <= '0;
                     dout_q  <= s2;
`ifdef INPUT_DEBOUNCE_EDGE_EN
                     rise_q  <= s2;
                     fall_q  <= ~s2;
`endif
                  end else begin
                     cnt_q <= cnt_q + CntOne;
                  end
               end
               default: begin
                  state_q <= StStable;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   assign dout = dout_q;

`ifdef INPUT_DEBOUNCE_EDGE_EN
   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed self-checking bench for input_debounce (STABLE_CYCLES=4, RESET_LEVEL=0).
// Edge pulses are expected only when INPUT_DEBOUNCE_EDGE_EN is defined.
module tb_input_debounce;

   logic clk;
   logic rst;
   logic en;
   logic din;
   logic dout;
   logic rise;
   logic fall;

   int n_checks;
   int n_fail;

`ifdef INPUT_DEBOUNCE_EDGE_EN
   localparam bit EdgeOn = 1'b1;
`else
   localparam bit EdgeOn = 1'b0;
`endif

   input_debounce #(
      .STABLE_CYCLES(4),
      .CNT_W        (8),
      .RESET_LEVEL  (1'b0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .din (din),
      .dout(dout),
      .rise(rise),
      .fall(fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one posedge and sample 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [2:0] exp;
      rst = 1'b0;
      en  = 1'b1;
      din = 1'b1;
      exp = 3'b000;
      #1;
      n_checks++;
      if ({dout, rise, fall} !== exp) begin
         n_fail++;
         $display("FAIL reset_async: {dout,rise,fall} got %b want %b", {dout, rise, fall}, exp);
      end
      for (int e = 1; e <= 5; e++) begin
         tick();
         n_checks++;
         if ({dout, rise, fall} !== exp) begin
            n_fail++;
            $display("FAIL reset_hold edge %0d: got %b want %b", e, {dout, rise, fall}, exp);
         end
      end
      din = 1'b0;
      rst = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      n_checks++;
      if ({dout, rise, fall} !== exp) begin
         n_fail++;
         $display("FAIL reset_release: got %b want %b", {dout, rise, fall}, exp);
      end
   endtask

   // Drive din to lvl from a settled opposite level; dout follows at the 6th edge.
   task automatic test_clean_edge(input logic lvl, input string name);
      logic [2:0] exp;
      din = lvl;
      for (int e = 1; e <= 8; e++) begin
         tick();
         exp[2] = (e >= 6) ? lvl : ~lvl;
         exp[1] = EdgeOn && (e == 6) && lvl;
         exp[0] = EdgeOn && (e == 6) && !lvl;
         n_checks++;
         if ({dout, rise, fall} !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: {dout,rise,fall} got %b want %b",
                     name, e, {dout, rise, fall}, exp);
         end
      end
   endtask

   task automatic test_bounce();
      din = 1'b1;
      tick();
      tick();
      din = 1'b0;
      for (int e = 3; e <= 12; e++) begin
         tick();
         n_checks++;
         if ({dout, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL bounce edge %0d: got %b want 000", e, {dout, rise, fall});
         end
      end
   endtask

   task automatic test_enable_freeze();
      logic [2:0] exp;
      din = 1'b1;
      en  = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      en = 1'b0;
      for (int e = 5; e <= 14; e++) begin
         tick();
         n_checks++;
         if ({dout, rise, fall} !== 3'b000) begin
            n_fail++;
            $display("FAIL freeze edge %0d: got %b want 000", e, {dout, rise, fall});
         end
      end
      en = 1'b1;
      for (int e = 15; e <= 17; e++) begin
         tick();
         exp = {(e >= 16), EdgeOn && (e == 16), 1'b0};
         n_checks++;
         if ({dout, rise, fall} !== exp) begin
            n_fail++;
            $display("FAIL freeze_resume edge %0d: got %b want %b", e, {dout, rise, fall}, exp);
         end
      end
      din = 1'b0;
      for (int e = 1; e <= 8; e++) tick();
      n_checks++;
      if (dout !== 1'b0) begin
         n_fail++;
         $display("FAIL freeze_return: dout got %b want 0", dout);
      end
   endtask

   task automatic test_reset_mid_check();
      logic [2:0] exp;
      din = 1'b1;
      for (int e = 1; e <= 4; e++) tick();
      rst = 1'b0;
      #1;
      n_checks++;
      if ({dout, rise, fall} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid: got %b want 000", {dout, rise, fall});
      end
      tick();
      tick();
      n_checks++;
      if ({dout, rise, fall} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_hold: got %b want 000", {dout, rise, fall});
      end
      rst = 1'b1;
      for (int e = 1; e <= 7; e++) begin
         tick();
         exp = {(e >= 6), EdgeOn && (e == 6), 1'b0};
         n_checks++;
         if ({dout, rise, fall} !== exp) begin
            n_fail++;
            $display("FAIL reset_mid_after edge %0d: got %b want %b", e, {dout, rise, fall}, exp);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      en       = 1'b0;
      din      = 1'b0;
      test_reset();
      test_clean_edge(1'b1, "clean_rise");
      test_clean_edge(1'b0, "clean_fall");
      test_bounce();
      test_enable_freeze();
      test_reset_mid_check();
      test_clean_edge(1'b0, "fall_after_reset");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
